// File: rtl/window_reg_kxk_pkg.sv
// Shared types and constants for the KxK sliding-window register.
// The optional WINDOW_ZERO_PAD_EN build uses pad_width() for "same" padding.
package window_reg_kxk_pkg;

  typedef enum logic [1:0] {
    S_FILL,
    S_RUN,
    S_TAIL
  } win_state_t;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_KERNEL     = 3;
  localparam int DEFAULT_IMG_WIDTH  = 8;

  function automatic int pad_width(input int kernel);
    return (kernel - 1) / 2;
  endfunction

endpackage

// File: rtl/window_reg_kxk_if.sv
// Column-in / window-out valid-ready bundle between line buffers, window register and MAC array.
interface window_reg_kxk_if
  import window_reg_kxk_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int KERNEL     = DEFAULT_KERNEL,
  parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH
);
  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  logic                                 in_valid;
  logic                                 in_ready;
  logic [KERNEL*DATA_WIDTH-1:0]         in_col;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  out_window;
  logic [CW-1:0]                        out_col_idx;
  logic                                 out_last;

  modport master (
    output in_valid, in_col, out_ready,
    input  in_ready, out_valid, out_window, out_col_idx, out_last
  );

  modport slave (
    input  in_valid, in_col, out_ready,
    output in_ready, out_valid, out_window, out_col_idx, out_last
  );

endinterface

// File: rtl/window_reg_kxk_row_shift.sv
// One K-deep row of the sliding window: column 0 is the newest pixel, column K-1 the oldest.
module window_reg_kxk_row_shift #(
  parameter int DATA_WIDTH = 16,
  parameter int KERNEL     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         shift_en,
  input  logic                         load_en,
  input  logic                         zero_en,
  input  logic [DATA_WIDTH-1:0]        din,
  output logic [KERNEL*DATA_WIDTH-1:0] row
);
  localparam int OLD_W = (KERNEL - 1) * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] pix;

  assign pix = zero_en ? '0 : din;

  // NOTE: the window registers are reset because their contents are visible on out_window.
  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
    end else if (load_en) begin
      row <= {{OLD_W{1'b0}}, pix};
    end else if (shift_en) begin
      row <= {row[OLD_W-1:0], pix};
    end
  end

endmodule

// File: rtl/window_reg_kxk.sv
// KxK sliding-window register: shifts in line-buffer columns and emits complete windows.
// Define WINDOW_ZERO_PAD_EN for "same" zero padding (IMG_WIDTH windows per row).
module window_reg_kxk
  import window_reg_kxk_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int KERNEL     = DEFAULT_KERNEL,
  parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH
) (
  input logic             clk,
  input logic             Rst_window,
  window_reg_kxk_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int K  = KERNEL;
  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);

  win_state_t          state;
  logic [CW-1:0]       col_cnt;
  logic [CW-1:0]       idx_cnt;
  logic [K*K*DW-1:0]   window_q;

  logic slot_free, accept, row_wrap, win_on_accept;
  logic tail_step, row_load, emit, emit_last;

  assign slot_free     = !bus.out_valid || bus.out_ready;
  assign bus.in_ready  = slot_free && (state != S_TAIL);
  assign accept        = bus.in_valid && bus.in_ready;
  assign row_wrap      = accept && (col_cnt == LAST_COL);

`ifdef WINDOW_ZERO_PAD_EN
  localparam int P = pad_width(KERNEL);
  localparam logic [CW-1:0] FIRST_WIN_COL = CW'(P);
  localparam logic [CW-1:0] LAST_TAIL     = CW'(P - 1);

  // During the tail col_cnt counts the inserted zero columns.
  assign tail_step = (state == S_TAIL) && slot_free;
  assign row_load  = accept && (col_cnt == '0);
  assign emit_last = tail_step && (col_cnt == LAST_TAIL);
`else
  localparam logic [CW-1:0] FIRST_WIN_COL = CW'(KERNEL - 1);

  assign tail_step = 1'b0;
  assign row_load  = 1'b0;
  assign emit_last = row_wrap;
`endif

  assign win_on_accept = accept && ((state == S_RUN) || (col_cnt == FIRST_WIN_COL));
  assign emit          = win_on_accept || tail_step;

  for (genvar r = 0; r < K; r++) begin : g_row
    window_reg_kxk_row_shift #(
      .DATA_WIDTH (DW),
      .KERNEL     (K)
    ) u_row (
      .clk      (clk),
      .rst      (Rst_window),
      .shift_en (accept || tail_step),
      .load_en  (row_load),
      .zero_en  (tail_step),
      .din      (bus.in_col[r*DW +: DW]),
      .row      (window_q[r*K*DW +: K*DW])
    );
  end

  assign bus.out_window = window_q;

  always_ff @(posedge clk) begin
    if (Rst_window) begin
      state           <= S_FILL;
      col_cnt         <= '0;
      idx_cnt         <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_last    <= 1'b0;
      bus.out_col_idx <= '0;
    end else begin
      if (emit) begin
        bus.out_valid   <= 1'b1;
        bus.out_last    <= emit_last;
        bus.out_col_idx <= idx_cnt;
        idx_cnt         <= emit_last ? '0 : idx_cnt + 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
      end

      if (row_wrap) begin
        col_cnt <= '0;
`ifdef WINDOW_ZERO_PAD_EN
        state   <= S_TAIL;
`else
        state   <= S_FILL;
`endif
      end else if (accept) begin
        col_cnt <= col_cnt + 1'b1;
        if (win_on_accept) state <= S_RUN;
      end
`ifdef WINDOW_ZERO_PAD_EN
      else if (tail_step) begin
        if (emit_last) begin
          col_cnt <= '0;
          state   <= S_FILL;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_window_reg_kxk.sv
// Scoreboard bench for window_reg_kxk (K=3, IMG_WIDTH=8, DW=16); also builds with WINDOW_ZERO_PAD_EN.
module tb_window_reg_kxk;
  import window_reg_kxk_pkg::*;

  localparam int DW = 16;
  localparam int K  = 3;
  localparam int W  = 8;
  localparam int P  = pad_width(K);
  localparam int CW = $clog2(W);
`ifdef WINDOW_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int WIN_PER_ROW = PAD ? W : W - K + 1;
  localparam int ROW_CYCLES  = W + (PAD ? P : 0);

  typedef struct packed {
    logic [K*K*DW-1:0] win;
    logic [CW-1:0]     idx;
    logic              last;
  } exp_t;

  logic clk;
  logic Rst_window;

  window_reg_kxk_if #(.DATA_WIDTH(DW), .KERNEL(K), .IMG_WIDTH(W)) bus ();

  window_reg_kxk #(
    .DATA_WIDTH (DW),
    .KERNEL     (K),
    .IMG_WIDTH  (W)
  ) dut (
    .clk        (clk),
    .Rst_window (Rst_window),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  int win_seen;
  int stale_hits;
  logic s_acc;
  logic s_in_ready;
  logic [K*K*DW-1:0] s_win;

  function automatic logic [DW-1:0] pix(input int row, input int col, input int lane);
    return {4'(row), 4'(col), 4'h0, 4'(lane)};
  endfunction

  function automatic logic [K*DW-1:0] col_vec(input int row, input int col);
    logic [K*DW-1:0] v;
    for (int r = 0; r < K; r++) v[r*DW +: DW] = pix(row, col, r);
    return v;
  endfunction

  // Reference: window w has newest column n; element (r,c) is column n-c, zero outside the row.
  task automatic push_row(input int row);
    for (int w = 0; w < WIN_PER_ROW; w++) begin
      exp_t e;
      int n;
      n = PAD ? w + P : w + K - 1;
      e.win = '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          if (n - c >= 0 && n - c < W) e.win[(r*K+c)*DW +: DW] = pix(row, n - c, r);
      e.idx  = CW'(w);
      e.last = (w == WIN_PER_ROW - 1);
      sb.push_back(e);
    end
  endtask

  task automatic sb_clear();
    sb.delete();
    win_seen   = 0;
    stale_hits = 0;
  endtask

  // Drive one cycle from a negedge, sample 1 time unit later, pop/compare any consumed window.
  task automatic step(input logic v, input logic [K*DW-1:0] col, input logic ordy);
    bus.in_valid  = v;
    bus.in_col    = col;
    bus.out_ready = ordy;
    #1;
    s_in_ready = bus.in_ready;
    s_acc      = v && bus.in_ready;
    s_win      = bus.out_window;
    if (bus.out_valid && ordy) begin
      exp_t got;
      exp_t e;
      got.win  = bus.out_window;
      got.idx  = bus.out_col_idx;
      got.last = bus.out_last;
      win_seen++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL extra_window got win=%h idx=%0d last=%0b, none expected",
                 got.win, got.idx, got.last);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL window_%0d got win=%h idx=%0d last=%0b expected win=%h idx=%0d last=%0b",
                   win_seen, got.win, got.idx, got.last, e.win, e.idx, e.last);
        end
      end
      if (win_seen > WIN_PER_ROW)
        for (int i = 0; i < K*K; i++)
          if (got.win[i*DW+8 +: 8] == 8'h07) stale_hits++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Stream columns start_col..rows*W-1 with out_ready=1 until all accepted and the scoreboard drains.
  task automatic stream(input int rows, input int row0, input int start_col,
                        input int budget, output int cycles);
    int col;
    col    = start_col;
    cycles = 0;
    while ((col < rows*W || sb.size() != 0) && cycles < budget) begin
      step(col < rows*W, col_vec(row0 + col / W, col % W), 1'b1);
      if (s_acc) col++;
      cycles++;
    end
    checks++;
    if (col != rows*W || sb.size() != 0) begin
      errors++;
      $display("FAIL stream_timeout got cols=%0d pending=%0d expected cols=%0d pending=0",
               col, sb.size(), rows*W);
    end
  endtask

  task automatic test_reset();
    Rst_window    = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_col    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    Rst_window = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.out_window !== '0) begin
      errors++; $display("FAIL reset_window got %h expected 0", bus.out_window);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b expected 1", bus.in_ready);
    end
    checks++;
    if (bus.out_col_idx !== '0) begin
      errors++; $display("FAIL reset_col_idx got %0d expected 0", bus.out_col_idx);
    end
    checks++;
    if (bus.out_last !== 1'b0) begin
      errors++; $display("FAIL reset_out_last got %b expected 0", bus.out_last);
    end
  endtask

  task automatic test_single_row();
    int cycles;
    sb_clear();
    push_row(0);
    stream(1, 0, 0, 100, cycles);
    checks++;
    if (win_seen != WIN_PER_ROW) begin
      errors++; $display("FAIL row_window_count got %0d expected %0d", win_seen, WIN_PER_ROW);
    end
    checks++;
    if (cycles != ROW_CYCLES + 1) begin
      errors++; $display("FAIL row_cycles got %0d expected %0d", cycles, ROW_CYCLES + 1);
    end
  endtask

  task automatic test_backpressure();
    int col;
    int cyc;
    int cycles;
    logic [K*K*DW-1:0] held;
    sb_clear();
    push_row(0);
    col = 0;
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      step(col < W, col_vec(0, col), 1'b0);
      if (s_acc) col++;
      cyc++;
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_first_window got out_valid=%b expected 1", bus.out_valid);
    end
    held = bus.out_window;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, col_vec(0, col), 1'b0);
      checks++;
      if (s_in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_in_ready cycle %0d got %b expected 0", i, s_in_ready);
      end
      checks++;
      if (s_win !== held) begin
        errors++; $display("FAIL bp_window_stable cycle %0d got %h expected %h", i, s_win, held);
      end
    end
    stream(1, 0, col, 100, cycles);
    checks++;
    if (win_seen != WIN_PER_ROW) begin
      errors++; $display("FAIL bp_window_count got %0d expected %0d", win_seen, WIN_PER_ROW);
    end
  endtask

  task automatic test_back_to_back();
    int cycles;
    sb_clear();
    push_row(0);
    push_row(1);
    stream(2, 0, 0, 200, cycles);
    checks++;
    if (cycles != 2*ROW_CYCLES + 1) begin
      errors++; $display("FAIL b2b_throughput got %0d cycles expected %0d", cycles, 2*ROW_CYCLES + 1);
    end
    checks++;
    if (win_seen != 2*WIN_PER_ROW) begin
      errors++; $display("FAIL b2b_window_count got %0d expected %0d", win_seen, 2*WIN_PER_ROW);
    end
    checks++;
    if (stale_hits != 0) begin
      errors++; $display("FAIL b2b_stale_column got %0d stale pixels expected 0", stale_hits);
    end
  endtask

`ifdef WINDOW_ZERO_PAD_EN
  task automatic test_zero_pad();
    int col;
    int post;
    int cyc;
    sb_clear();
    push_row(0);
    col  = 0;
    post = 0;
    cyc  = 0;
    while ((col < W || sb.size() != 0) && cyc < 100) begin
      step((col < W) || (post < P), col_vec(0, col % W), 1'b1);
      if (col >= W) begin
        if (post < P) begin
          checks++;
          if (s_in_ready !== 1'b0) begin
            errors++; $display("FAIL pad_tail_in_ready insert %0d got %b expected 0", post, s_in_ready);
          end
        end
        post++;
      end else if (s_acc) begin
        col++;
      end
      cyc++;
    end
    checks++;
    if (win_seen != W || sb.size() != 0) begin
      errors++; $display("FAIL pad_window_count got %0d expected %0d", win_seen, W);
    end
  endtask
`endif

  task automatic test_mid_row_reset();
    int cycles;
    int col;
    int cyc;
    sb_clear();
    push_row(0);
    col = 0;
    cyc = 0;
    while (col < 4 && cyc < 20) begin
      step(1'b1, col_vec(0, col), 1'b1);
      if (s_acc) col++;
      cyc++;
    end
    Rst_window = 1'b1;
    step(1'b0, '0, 1'b0);
    Rst_window = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_out_valid got %b expected 0", bus.out_valid);
    end
    sb_clear();
    push_row(0);
    stream(1, 0, 0, 100, cycles);
    checks++;
    if (win_seen != WIN_PER_ROW) begin
      errors++; $display("FAIL midreset_window_count got %0d expected %0d", win_seen, WIN_PER_ROW);
    end
    checks++;
    if (cycles != ROW_CYCLES + 1) begin
      errors++; $display("FAIL midreset_cycles got %0d expected %0d", cycles, ROW_CYCLES + 1);
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_backpressure();
    test_back_to_back();
`ifdef WINDOW_ZERO_PAD_EN
    test_zero_pad();
`endif
    test_mid_row_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
